// File: rtl/sram_ctrl.sv
// sram_ctrl: single-requester sequencer between a user request/response
// interface and the sram_io_ice40 pad-side ports. One read or write is in
// flight at a time. Each request becomes an ordered sequence of
// ce_n/we_n/oe_n/data-enable strobes. Read data is collected from
// pad_read_data_valid, and a timeout flags a response that never arrives.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_we/addr/wdata       request fields, sampled only at acceptance
//   rd_valid/rd_data/rd_err read response pulse; rd_data holds until next read
//   wr_done                 write completion pulse
//   pad_*                   registered strobes/data towards sram_io_ice40,
//                           plus the read data/valid coming back from it
module sram_ctrl #(
  parameter int ADDR_BITS    = 20,
  parameter int DATA_BITS    = 16,
  parameter int READ_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_err,
  output logic                 wr_done,
  output logic [ADDR_BITS-1:0] pad_addr,
  output logic [DATA_BITS-1:0] pad_write_data,
  output logic                 pad_write_data_enable,
  output logic                 pad_ce_n,
  output logic                 pad_we_n,
  output logic                 pad_oe_n,
  input  logic [DATA_BITS-1:0] pad_read_data,
  input  logic                 pad_read_data_valid
);

  localparam int CNT_W = $clog2(READ_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    WR_HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      cnt                   <= '0;
      pad_ce_n              <= 1'b1;
      pad_we_n              <= 1'b1;
      pad_oe_n              <= 1'b1;
      pad_write_data_enable <= 1'b0;
      pad_addr              <= '0;
      pad_write_data        <= '0;
      rd_valid              <= 1'b0;
      rd_err                <= 1'b0;
      rd_data               <= '0;
      wr_done               <= 1'b0;
    end else begin
      // Response strobes are single-cycle pulses unless re-asserted below.
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      wr_done  <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            pad_addr <= req_addr;
            pad_ce_n <= 1'b0;
            if (req_we) begin
              pad_write_data        <= req_wdata;
              pad_we_n              <= 1'b0;
              pad_write_data_enable <= 1'b1;
              state                 <= WR;
            end else begin
              pad_oe_n <= 1'b0;
              state    <= RD;
            end
          end
        end

        // oe_n is a single-cycle launch strobe; the pad block captures the
        // data and reports it later through pad_read_data_valid.
        RD: begin
          pad_oe_n <= 1'b1;
          cnt      <= '0;
          state    <= RD_WAIT;
        end

        // A valid arriving on the last wait cycle still wins over timeout.
        RD_WAIT: begin
          if (pad_read_data_valid) begin
            rd_data  <= pad_read_data;
            rd_valid <= 1'b1;
            pad_ce_n <= 1'b1;
            state    <= IDLE;
          end else if (cnt == CNT_LAST) begin
            rd_data  <= '0;
            rd_valid <= 1'b1;
            rd_err   <= 1'b1;
            pad_ce_n <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // we_n rises here while address, data and data enable stay put,
        // giving the SRAM data hold time after the write edge.
        WR: begin
          pad_we_n <= 1'b1;
          state    <= WR_HOLD;
        end

        WR_HOLD: begin
          pad_ce_n              <= 1'b1;
          pad_write_data_enable <= 1'b0;
          wr_done               <= 1'b1;
          state                 <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
